// File: rtl/rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : rst_seq_gen
// Brief    : Cycle-counted reset sequencer: pre-delay, hold, staggered
//            per-channel release, then wait for controller init-done.
//            Optional WAIT_INIT watchdog enabled by RST_SEQ_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module rst_seq_gen #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 16,
    parameter int PRE_DLY      = 10,
    parameter int ASSERT_LEN   = 100,
    parameter int STAGGER      = 10,
    parameter int INIT_TIMEOUT = 1000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic              init_done_i,
    output logic [NUM_CH-1:0] rst_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [2:0]        phase_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRE     = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_WAIT    = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } state_e;

    localparam int LAST_REL = (NUM_CH - 1) * STAGGER;

    // Saturation point: the largest count any state ever compares against.
    localparam int NEED_1 = (PRE_DLY > ASSERT_LEN) ? PRE_DLY : ASSERT_LEN;
    localparam int NEED_2 = (NEED_1 > LAST_REL) ? NEED_1 : LAST_REL;
    localparam int NEED   = (NEED_2 > INIT_TIMEOUT) ? NEED_2 : INIT_TIMEOUT;
    localparam longint CNT_ALL1 = (longint'(1) << CNT_W) - longint'(1);
    localparam logic [CNT_W-1:0] CNT_SAT =
        CNT_W'((longint'(NEED) < CNT_ALL1) ? longint'(NEED) : CNT_ALL1);

    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'((PRE_DLY > 0) ? PRE_DLY - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((ASSERT_LEN > 0) ? ASSERT_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'((LAST_REL > 0) ? LAST_REL - 1 : 0);
`ifdef RST_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'((INIT_TIMEOUT > 0) ? INIT_TIMEOUT - 1 : 0);
`endif

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CNT_W:0]    cnt_nxt;
    logic [NUM_CH-1:0] rst_n_q, rst_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef RST_SEQ_WATCHDOG_EN
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        cnt_inc = (cnt_q >= CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        cnt_nxt = {1'b0, cnt_q} + (CNT_W + 1)'(1);
        state_d = state_q;
        cnt_d   = cnt_inc;
        rst_n_d = rst_n_q;

        case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                cnt_d = '0;
                if (start_i) begin
                    if (PRE_DLY == 0) begin
                        state_d = ST_HOLD;
                        rst_n_d = '0;
                    end else begin
                        state_d = ST_PRE;
                        rst_n_d = '1;
                    end
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    rst_n_d = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = '0;
                    if (LAST_REL == 0) begin
                        state_d = ST_WAIT;
                        rst_n_d = '1;
                    end else begin
                        state_d    = ST_RELEASE;
                        rst_n_d    = '0;
                        rst_n_d[0] = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                // cnt_nxt is the number of cycles since RELEASE entry after this edge
                for (int k = 0; k < NUM_CH; k++) begin
                    if (cnt_nxt >= (CNT_W + 1)'(k * STAGGER)) begin
                        rst_n_d[k] = 1'b1;
                    end
                end
                if (cnt_q == REL_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (init_done_i) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end
`ifdef RST_SEQ_WATCHDOG_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = ST_FAIL;
                    cnt_d   = '0;
                    rst_n_d = '0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                rst_n_d = '1;
            end
        endcase

        busy_d = (state_d == ST_PRE) || (state_d == ST_HOLD) ||
                 (state_d == ST_RELEASE) || (state_d == ST_WAIT);
        done_d = (state_d == ST_DONE);
`ifdef RST_SEQ_WATCHDOG_EN
        timeout_d = (state_d == ST_FAIL);
`endif
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rst_n_q   <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RST_SEQ_WATCHDOG_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_n_q   <= rst_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef RST_SEQ_WATCHDOG_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign rst_n_o = rst_n_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign phase_o = state_q;
`ifdef RST_SEQ_WATCHDOG_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rst_seq_gen
// Brief    : Self-checking bench for rst_seq_gen (default and edge-parameter
//            instances) against a timeline-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rst_seq_gen;

    localparam int P0 = 10, A0 = 100, S0 = 10, N0 = 2, T0 = 1000;
    localparam int P1 = 0,  A1 = 100, S1 = 0,  N1 = 4, T1 = 1000;
`ifdef RST_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_FAIL = 3;

    logic wb_clk_i = 1'b0;
    logic rst = 1'b1, start = 1'b0, idone = 1'b0;

    logic [N0-1:0] rst_n0;
    logic          busy0, done0, tmo0;
    logic [2:0]    ph0;
    logic [N1-1:0] rst_n1;
    logic          busy1, done1, tmo1;
    logic [2:0]    ph1;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;
    int base = 0;
    int mst [2] = '{M_IDLE, M_IDLE};
    int mt0 [2] = '{0, 0};

    always #5 wb_clk_i = ~wb_clk_i;

    rst_seq_gen #(.NUM_CH(N0), .CNT_W(16), .PRE_DLY(P0), .ASSERT_LEN(A0),
                  .STAGGER(S0), .INIT_TIMEOUT(T0)) dut0 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(rst), .start_i(start), .init_done_i(idone),
        .rst_n_o(rst_n0), .busy_o(busy0), .done_o(done0), .timeout_o(tmo0), .phase_o(ph0));

    rst_seq_gen #(.NUM_CH(N1), .CNT_W(16), .PRE_DLY(P1), .ASSERT_LEN(A1),
                  .STAGGER(S1), .INIT_TIMEOUT(T1)) dut1 (
        .wb_clk_i(wb_clk_i), .wb_rst_i(rst), .start_i(start), .init_done_i(idone),
        .rst_n_o(rst_n1), .busy_o(busy1), .done_o(done1), .timeout_o(tmo1), .phase_o(ph1));

    // Offset (from sequence entry) of the cycle WAIT_INIT is entered.
    function automatic int roff(input int id);
        return (id == 0) ? P0 + A0 + (N0 - 1) * S0 : P1 + A1 + (N1 - 1) * S1;
    endfunction

    // Reference model: tracks only the start cycle and the terminal outcome.
    always @(posedge wb_clk_i) begin
        cyc = cyc + 1;
        for (int id = 0; id < 2; id++) begin
            if (rst) mst[id] = M_IDLE;
            else if (mst[id] != M_RUN) begin
                if (start) begin
                    mst[id] = M_RUN;
                    mt0[id] = cyc;
                end
            end else if ((cyc - mt0[id] >= roff(id) + 1) && idone) mst[id] = M_DONE;
            else if (WD && (cyc - mt0[id] == roff(id) + ((id == 0) ? T0 : T1))) mst[id] = M_FAIL;
        end
    end

    task automatic expect_out(input int id, output logic [15:0] rn, output logic [2:0] ph,
                              output logic b, output logic d, output logic t);
        int p, a, s, n, off;
        p = (id == 0) ? P0 : P1;
        a = (id == 0) ? A0 : A1;
        s = (id == 0) ? S0 : S1;
        n = (id == 0) ? N0 : N1;
        rn = 16'h0;
        for (int k = 0; k < n; k++) rn[k] = 1'b1;
        ph = 3'd0; b = 1'b0; d = 1'b0; t = 1'b0;
        case (mst[id])
            M_DONE: begin ph = 3'd5; d = 1'b1; end
            M_FAIL: begin ph = 3'd6; t = 1'b1; rn = 16'h0; end
            M_RUN: begin
                off = cyc - mt0[id];
                b = 1'b1;
                if (off < p) ph = 3'd1;
                else if (off < p + a) begin ph = 3'd2; rn = 16'h0; end
                else if (off < roff(id)) begin
                    ph = 3'd3;
                    rn = 16'h0;
                    for (int k = 0; k < n; k++) if (off >= p + a + k * s) rn[k] = 1'b1;
                end else ph = 3'd4;
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [15:0] rn; logic [2:0] ph; logic b, d, t;
        expect_out(0, rn, ph, b, d, t);
        chk("d0_rst_n", {14'b0, rst_n0}, rn);
        chk("d0_phase", {13'b0, ph0}, {13'b0, ph});
        chk("d0_busy", {15'b0, busy0}, {15'b0, b});
        chk("d0_done", {15'b0, done0}, {15'b0, d});
        chk("d0_timeout", {15'b0, tmo0}, {15'b0, t});
        expect_out(1, rn, ph, b, d, t);
        chk("d1_rst_n", {12'b0, rst_n1}, rn);
        chk("d1_phase", {13'b0, ph1}, {13'b0, ph});
        chk("d1_busy", {15'b0, busy1}, {15'b0, b});
        chk("d1_done", {15'b0, done1}, {15'b0, d});
        chk("d1_timeout", {15'b0, tmo1}, {15'b0, t});
    endtask

    task automatic tick();
        @(negedge wb_clk_i);
        check_all();
    endtask

    task automatic run_to(input int rel);
        while (cyc < base + rel) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tick(); tick(); tick();
        chk("reset_rst_n", {14'b0, rst_n0}, 16'h3);
        chk("reset_phase", {13'b0, ph0}, 16'h0);
        chk("reset_busy", {15'b0, busy0}, 16'h0);
        chk("reset_done", {15'b0, done0}, 16'h0);
        rst = 1'b0;

        // Nominal sequence
        base = cyc; idone = 1'b0; pulse_start();
        chk("nom_phase_1", {13'b0, ph0}, 16'h1);
        chk("edge_rst_n_1", {12'b0, rst_n1}, 16'h0);
        run_to(10);  chk("nom_rst_n_10", {14'b0, rst_n0}, 16'h3);
        run_to(11);  chk("nom_rst_n_11", {14'b0, rst_n0}, 16'h0);
        run_to(101); chk("edge_rst_n_101", {12'b0, rst_n1}, 16'hf);
        run_to(111); chk("nom_rst_n_111", {14'b0, rst_n0}, 16'h1);
        run_to(121); chk("nom_rst_n_121", {14'b0, rst_n0}, 16'h3);
        chk("nom_phase_121", {13'b0, ph0}, 16'h4);
        run_to(130); idone = 1'b1;
        tick();
        chk("nom_done_131", {15'b0, done0}, 16'h1);
        chk("nom_busy_131", {15'b0, busy0}, 16'h0);
        run_to(135); idone = 1'b0;
        tick(); tick();
        chk("done_sticky", {15'b0, done0}, 16'h1);

        // Restart from DONE, with a start pulse ignored during HOLD
        base = cyc; pulse_start();
        chk("rerun_phase_1", {13'b0, ph0}, 16'h1);
        chk("rerun_done_clr", {15'b0, done0}, 16'h0);
        run_to(50); pulse_start();
        run_to(111); chk("ign_rst_n_111", {14'b0, rst_n0}, 16'h1);
        run_to(121); chk("ign_rst_n_121", {14'b0, rst_n0}, 16'h3);
`ifdef RST_SEQ_WATCHDOG_EN
        run_to(1121);
        chk("wd_phase_1121", {13'b0, ph0}, 16'h6);
        chk("wd_timeout_1121", {15'b0, tmo0}, 16'h1);
        chk("wd_rst_n_1121", {14'b0, rst_n0}, 16'h0);
        run_to(1200); pulse_start();
        chk("wd_timeout_1201", {15'b0, tmo0}, 16'h0);
        chk("wd_phase_1201", {13'b0, ph0}, 16'h1);
        do_reset();
        // init_done arriving on the timeout edge itself
        base = cyc; pulse_start();
        run_to(1120); idone = 1'b1;
        tick();
        chk("wd_race_done", {15'b0, done0}, 16'h1);
        chk("wd_race_timeout", {15'b0, tmo0}, 16'h0);
        idone = 1'b0;
`else
        run_to(5000);
        chk("nowd_phase_5000", {13'b0, ph0}, 16'h4);
        chk("nowd_timeout_5000", {15'b0, tmo0}, 16'h0);
        idone = 1'b1;
        tick();
        chk("nowd_done_5001", {15'b0, done0}, 16'h1);
        idone = 1'b0;
`endif
        do_reset();

        // Edge parameters with init_done already high
        idone = 1'b1;
        base = cyc; pulse_start();
        chk("edge_hold_1", {12'b0, rst_n1}, 16'h0);
        chk("edge_phase_1", {13'b0, ph1}, 16'h2);
        run_to(101); chk("edge_rel_101", {12'b0, rst_n1}, 16'hf);
        run_to(102); chk("edge_done_102", {15'b0, done1}, 16'h1);
        run_to(122); chk("d0_done_122", {15'b0, done0}, 16'h1);
        idone = 1'b0;

        // Mid-sequence reset
        base = cyc; pulse_start();
        run_to(50); rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_rst_n_51", {14'b0, rst_n0}, 16'h3);
        chk("midrst_phase_51", {13'b0, ph0}, 16'h0);
        chk("midrst_busy_51", {15'b0, busy0}, 16'h0);

        // Randomised traffic against the model
        for (int i = 0; i < 4000; i++) begin
            rst   = ($urandom_range(999) == 0);
            start = ($urandom_range(149) == 0);
            if ($urandom_range(199) == 0) idone = ~idone;
            tick();
        end
        rst = 1'b0; start = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rst_seq_gen.md
# rst_seq_gen

Synthesizable, parametrised reset sequencer for the emulation top level. It replaces fixed-delay behavioural reset generation with a cycle-counted sequence: pre-delay, assert, staggered per-channel release, then a wait for the controller's `sdr_init_done`. It drives `NUM_CH` active-low downstream resets, such as the Wishbone side and the SDRAM side, from one clock domain. Status outputs let the bench gate traffic until initialisation completes.

## Interface
- `NUM_CH`, 2 — number of downstream reset channels (1..16)
- `CNT_W`, 16 — width of the shared cycle counter
- `PRE_DLY`, 10 — cycles between start and reset assertion (0 allowed)
- `ASSERT_LEN`, 100 — cycles all channels are held in reset (≥1)
- `STAGGER`, 10 — cycles between release of channel k and k+1 (0 allowed)
- `INIT_TIMEOUT`, 1000 — maximum WAIT_INIT cycles (watchdog only)

Ports:
- `wb_clk_i` in 1 — single clock; all inputs synchronous to it
- `wb_rst_i` in 1 — synchronous, active-high reset
- `start_i` in 1 — single-cycle request to run the sequence
- `init_done_i` in 1 — initialisation complete (`sdr_init_done`)
- `rst_n_o` out `NUM_CH` — active-low channel resets; bit k is channel k
- `busy_o` out 1 — high in PRE, HOLD, RELEASE and WAIT_INIT
- `done_o` out 1 — sticky; high in DONE
- `timeout_o` out 1 — sticky; high in FAIL
- `phase_o` out 3 — state code: IDLE=0, PRE=1, HOLD=2, RELEASE=3, WAIT_INIT=4, DONE=5, FAIL=6

## Operation
- All outputs are registered.
- Reset values: `rst_n_o` = all ones, `busy_o` = 0, `done_o` = 0, `timeout_o` = 0, `phase_o` = 0. The counter clears to 0.
- IDLE: `start_i` moves to PRE, or directly to HOLD when `PRE_DLY` = 0. The counter clears on every state entry.
- PRE: `rst_n_o` stays all ones. After `PRE_DLY` cycles, go to HOLD.
- HOLD: `rst_n_o` = all zeros. After `ASSERT_LEN` cycles, go to RELEASE.
- RELEASE:
  - Channel 0 is released on entry.
  - Channel k is released k·`STAGGER` cycles after entry.
  - A released bit stays 1.
  - Go to WAIT_INIT on the same edge that releases channel `NUM_CH`-1. With `STAGGER` = 0, all channels release together.
- WAIT_INIT: `init_done_i` = 1 moves to DONE. The watchdog applies here (see Configuration).
- DONE: `done_o` = 1 and `busy_o` = 0. A later fall of `init_done_i` is ignored.
- FAIL: `timeout_o` = 1 and `rst_n_o` = all zeros (re-asserted).
- `start_i` handling:
  - Accepted in IDLE, DONE and FAIL; clears `done_o` and `timeout_o` on the transition.
  - Ignored in all busy states.
- `wb_rst_i` has priority over everything. Mid-sequence it returns to IDLE with reset values on the next edge.
- Counter width: `CNT_W` must hold max(`PRE_DLY`, `ASSERT_LEN`, (`NUM_CH`-1)·`STAGGER`, `INIT_TIMEOUT`). The counter saturates and never wraps.

## Timing
- Convention: cycle c means the value visible after clock edge c; `start_i` is sampled high at edge 0.
- PRE entered at cycle 1.
- `rst_n_o` = all zeros from cycle 1+`PRE_DLY`.
- Channel k rises at cycle 1+`PRE_DLY`+`ASSERT_LEN`+k·`STAGGER`.
- WAIT_INIT entered at the last release cycle R. `init_done_i` is sampled from edge R+1.
- `done_o` rises one cycle after `init_done_i` is sampled high, so the earliest is R+1 if `init_done_i` is already high.
- Watchdog: if `init_done_i` stays low for `INIT_TIMEOUT` samples, FAIL is entered at cycle R+`INIT_TIMEOUT`.
- If `init_done_i` rises on the timeout edge itself, DONE wins.

## Configuration
- `RST_SEQ_WATCHDOG_EN` defined: the WAIT_INIT timeout is active and FAIL is reachable.
- `RST_SEQ_WATCHDOG_EN` undefined:
  - WAIT_INIT waits indefinitely.
  - `timeout_o` is tied to 0.
  - FAIL is unreachable, and `INIT_TIMEOUT` is ignored for counter sizing.

## Test plan
All scenarios use defaults (`NUM_CH`=2, `PRE_DLY`=10, `ASSERT_LEN`=100, `STAGGER`=10, `INIT_TIMEOUT`=1000) unless stated.
- Nominal: `start_i` at 0 and `init_done_i` high at 130.
  - `rst_n_o`: 2'b11 through 10, 2'b00 at 11, 2'b01 at 111, 2'b11 at 121.
  - `done_o` = 1 at 131; `busy_o` low at 131.
- Watchdog (macro on): `init_done_i` never rises → `phase_o` = 6, `timeout_o` = 1 and `rst_n_o` = 2'b00 at 1121; `start_i` at 1200 restarts with `timeout_o` = 0 at 1201.
- Ignored start: pulse `start_i` at 50 (HOLD) → release times unchanged (111 and 121). A `start_i` pulse in DONE reruns the sequence.
- Mid-sequence reset: `wb_rst_i` at 50 → at 51, `rst_n_o` = 2'b11, `phase_o` = 0, `busy_o` = 0.
- Edge parameters (`PRE_DLY`=0, `STAGGER`=0, `NUM_CH`=4): `rst_n_o` = 4'b0000 at 1 and 4'b1111 at 101; `init_done_i` already high → `done_o` at 102.
- Macro off: `init_done_i` low for 5000 cycles → `phase_o` = 4, `timeout_o` = 0; raise `init_done_i` at 5000 → `done_o` at 5001.
